// File: rtl/countdown_time_setter.sv
// countdown_time_setter
// Button-driven BCD editor for the countdown start time. One digit is edited
// at a time (up/down/next/confirm). Up/down auto-repeat while held, results
// saturate at MIN_TIME/MAX_TIME, and the value locks on confirm or when the
// controller leaves setup. Editing re-opens on the controller's return to setup.
module countdown_time_setter #(
  parameter logic [11:0] DEFAULT_TIME = 12'h200,
  parameter logic [11:0] MIN_TIME     = 12'h010,
  parameter logic [11:0] MAX_TIME     = 12'h999,
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_RATE  = 5000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  game_state,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_next,
  input  logic        btn_confirm,
  output logic [11:0] init_time,
  output logic [1:0]  edit_digit,
  output logic        editing,
  output logic        time_valid
);

  localparam int unsigned MAXC = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int          CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DLY_C  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RATE_C = CW'(REPEAT_RATE);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  typedef enum logic {S_EDIT, S_LOCKED} state_t;

  // Single-digit BCD step with ripple carry/borrow into the higher digits.
  // Bit 12 of the result flags a carry/borrow out of the hundreds digit.
  function automatic logic [12:0] bcd_step(input logic [11:0] v, input logic [1:0] d,
                                           input logic up);
    logic [11:0] res;
    logic [3:0]  dig;
    logic        c;
    logic        act;
    res = v;
    c   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dig = v[4*i +: 4];
      act = (i == int'(d)) || c;
      if (act) begin
        if (up) begin
          if (dig == 4'd9) begin dig = 4'd0; c = 1'b1; end
          else begin dig = dig + 4'd1; c = 1'b0; end
        end else begin
          if (dig == 4'd0) begin dig = 4'd9; c = 1'b1; end
          else begin dig = dig - 4'd1; c = 1'b0; end
        end
      end
      res[4*i +: 4] = dig;
    end
    return {c, res};
  endfunction

  // Saturate a stepped value to [MIN_TIME, MAX_TIME]. Valid BCD compares
  // correctly as a plain unsigned vector, so no binary conversion is needed.
  function automatic logic [11:0] sat_time(input logic [12:0] s, input logic up);
    logic [11:0] res;
    if (s[12]) res = up ? MAX_TIME : MIN_TIME;
    else if (s[11:0] > MAX_TIME) res = MAX_TIME;
    else if (s[11:0] < MIN_TIME) res = MIN_TIME;
    else res = s[11:0];
    return res;
  endfunction

  // Button bit order: 0 up, 1 down, 2 next, 3 confirm
  logic [3:0]  w_btn;
  logic [3:0]  r_lvl;
  logic [3:0]  r_lvl_d;
  logic [3:0]  r_arm;
  logic [3:0]  w_ev;
  logic        r_setup_d;
  logic [CW-1:0] r_cnt [2];
  logic [1:0]  r_rate;
  logic [1:0]  w_rep;
  logic        w_in_setup;
  logic        w_up_act;
  logic        w_dn_act;
  logic [11:0] w_val_up;
  logic [11:0] w_val_dn;

  state_t      r_state;
  logic [11:0] r_val;
  logic [1:0]  r_digit;
  logic        r_editing;
  logic        r_time_valid;

  assign w_btn      = {btn_confirm, btn_next, btn_down, btn_up};
  assign w_in_setup = (game_state == 8'h00);
  // r_arm blocks a button held through reset from producing a press event
  assign w_ev       = r_lvl & ~r_lvl_d & r_arm;
  assign w_up_act   = w_ev[0] | w_rep[0];
  assign w_dn_act   = w_ev[1] | w_rep[1];
  assign w_val_up   = sat_time(bcd_step(r_val, r_digit, 1'b1), 1'b1);
  assign w_val_dn   = sat_time(bcd_step(r_val, r_digit, 1'b0), 1'b0);

  // Register button levels and setup flag for edge detection
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_lvl     <= '0;
      r_lvl_d   <= '0;
      r_arm     <= '0;
      r_setup_d <= 1'b0;
    end else begin
      r_lvl     <= w_btn;
      r_lvl_d   <= r_lvl;
      r_arm     <= r_arm | ~w_btn;
      r_setup_d <= w_in_setup;
    end
  end

  // Auto-repeat strobe: counter reaches the current threshold while held
  always_comb begin
    w_rep = '0;
    for (int i = 0; i < 2; i++) begin
      w_rep[i] = r_lvl[i] && (r_cnt[i] != '0) && !w_ev[i] &&
                 (r_cnt[i] == (r_rate[i] ? RATE_C : DLY_C));
    end
  end

  // Up/down hold counters: start at the press event, reload on each repeat, clear on release
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
      r_rate   <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_ev[i]) begin
          r_cnt[i]  <= ONE_C;
          r_rate[i] <= 1'b0;
        end else if (!r_lvl[i]) begin
          r_cnt[i]  <= '0;
          r_rate[i] <= 1'b0;
        end else if (w_rep[i]) begin
          r_cnt[i]  <= ONE_C;
          r_rate[i] <= 1'b1;
        end else if (r_cnt[i] != '0) begin
          r_cnt[i]  <= r_cnt[i] + ONE_C;
        end
      end
    end
  end

  // Edit/lock FSM with the time value, selected digit and status outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_EDIT;
      r_val        <= DEFAULT_TIME;
      r_digit      <= 2'd0;
      r_editing    <= 1'b1;
      r_time_valid <= 1'b0;
    end else begin
      case (r_state)
        S_EDIT: begin
          if (!w_in_setup || w_ev[3]) begin
            r_state      <= S_LOCKED;
            r_editing    <= 1'b0;
            r_time_valid <= 1'b1;
          end else if (w_ev[2]) begin
            r_digit <= (r_digit == 2'd2) ? 2'd0 : r_digit + 2'd1;
          end else if (w_up_act ^ w_dn_act) begin
            r_val <= w_up_act ? w_val_up : w_val_dn;
          end
        end
        S_LOCKED: begin
          if (w_in_setup && !r_setup_d) begin
            r_state      <= S_EDIT;
            r_digit      <= 2'd0;
            r_editing    <= 1'b1;
            r_time_valid <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_EDIT;
          r_editing    <= 1'b1;
          r_time_valid <= 1'b0;
        end
      endcase
    end
  end

  // Countdown expects {ones, tens, hundreds}; pure rewiring of the value register
  assign init_time  = {r_val[3:0], r_val[7:4], r_val[11:8]};
  assign edit_digit = r_digit;
  assign editing    = r_editing;
  assign time_valid = r_time_valid;

endmodule
